cmd_master: RTL and testbench

Command-path master of the SD host controller. It sits between the host register/control logic and the CMD physical-layer block: it accepts a command (index + argument), hands it to the physical layer over a REQ/ACK handshake, waits for the response with a programmable timeout, and returns the response index/argument with completion and error flags.

---
 rtl/cmd_master_if.sv | 33 +++
 rtl/cmd_master.sv | 115 +++++++++++
 tb/tb_cmd_master.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/cmd_master_if.sv
// Command-path bus between the host control logic, cmd_master and the CMD physical layer.
// The master modport is the cmd_master view; slave is the host/PHY side that drives it.
interface cmd_master_if;
  logic        new_cmd;
  logic        cmd_error;
  logic        ACK_in;
  logic        REQ_in;
  logic [31:0] cmd_arg;
  logic [5:0]  cmd_index;
  logic [15:0] timeout_value;
  logic [37:0] cmd_response;
  logic        cmd_busy;
  logic        cmd_complete;
  logic        cmd_index_error;
  logic        REQ_out;
  logic        ACK_out;
  logic        timeout_error;
  logic [31:0] response_arg;
  logic [5:0]  response_index;
  logic [37:0] cmd_out;

  modport master (
    input  new_cmd, cmd_error, ACK_in, REQ_in, cmd_arg, cmd_index, timeout_value, cmd_response,
    output cmd_busy, cmd_complete, cmd_index_error, REQ_out, ACK_out, timeout_error,
           response_arg, response_index, cmd_out
  );

  modport slave (
    output new_cmd, cmd_error, ACK_in, REQ_in, cmd_arg, cmd_index, timeout_value, cmd_response,
    input  cmd_busy, cmd_complete, cmd_index_error, REQ_out, ACK_out, timeout_error,
           response_arg, response_index, cmd_out
  );
endinterface

// File: rtl/cmd_master.sv
// SD host command-path master: issues a command to the CMD PHY over REQ/ACK, waits for the
// response under a programmable timeout and reports completion / index / timeout status.
module cmd_master (
  input logic          CLK_host,
  input logic          reset,
  cmd_master_if.master bus
);

  typedef enum logic [2:0] {StIdle, StSend, StWaitResp, StAck, StDone} state_e;

  state_e      state_q;
  logic [15:0] cnt_q;
  logic        cmd_busy_q;
  logic        cmd_complete_q;
  logic        cmd_index_error_q;
  logic        req_out_q;
  logic        ack_out_q;
  logic        timeout_error_q;
  logic [31:0] response_arg_q;
  logic [5:0]  response_index_q;
  logic [37:0] cmd_out_q;

  always_ff @(posedge CLK_host) begin
    if (!reset) begin
      state_q           <= StIdle;
      cnt_q             <= 16'd0;
      cmd_busy_q        <= 1'b0;
      cmd_complete_q    <= 1'b0;
      cmd_index_error_q <= 1'b0;
      req_out_q         <= 1'b0;
      ack_out_q         <= 1'b0;
      timeout_error_q   <= 1'b0;
      response_arg_q    <= 32'd0;
      response_index_q  <= 6'd0;
      cmd_out_q         <= 38'd0;
    end else begin
      cmd_complete_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.new_cmd) begin
            cmd_out_q         <= {bus.cmd_index, bus.cmd_arg};
            cmd_index_error_q <= 1'b0;
            timeout_error_q   <= 1'b0;
            cmd_busy_q        <= 1'b1;
            req_out_q         <= 1'b1;
            state_q           <= StSend;
          end
        end
        StSend: begin
          if (bus.cmd_error) begin
            req_out_q  <= 1'b0;
            ack_out_q  <= 1'b0;
            cmd_busy_q <= 1'b0;
            state_q    <= StIdle;
          end else if (bus.ACK_in) begin
            req_out_q <= 1'b0;
            cnt_q     <= 16'd0;
            state_q   <= StWaitResp;
          end
        end
        StWaitResp: begin
          if (bus.cmd_error) begin
            req_out_q  <= 1'b0;
            ack_out_q  <= 1'b0;
            cmd_busy_q <= 1'b0;
            state_q    <= StIdle;
          end else begin
            if (cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
            // A response arriving on the timeout edge still wins.
            if (bus.REQ_in) begin
              response_index_q  <= bus.cmd_response[37:32];
              response_arg_q    <= bus.cmd_response[31:0];
              cmd_index_error_q <= (bus.cmd_response[37:32] != cmd_out_q[37:32]);
              ack_out_q         <= 1'b1;
              state_q           <= StAck;
            end else if ((bus.timeout_value != 16'd0) &&
                         (cnt_q == bus.timeout_value - 16'd1)) begin
              timeout_error_q <= 1'b1;
              cmd_busy_q      <= 1'b0;
              state_q         <= StIdle;
            end
          end
        end
        StAck: begin
          if (bus.cmd_error) begin
            req_out_q  <= 1'b0;
            ack_out_q  <= 1'b0;
            cmd_busy_q <= 1'b0;
            state_q    <= StIdle;
          end else if (!bus.REQ_in) begin
            ack_out_q <= 1'b0;
            state_q   <= StDone;
          end
        end
        StDone: begin
          cmd_complete_q <= 1'b1;
          cmd_busy_q     <= 1'b0;
          state_q        <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.cmd_busy        = cmd_busy_q;
  assign bus.cmd_complete    = cmd_complete_q;
  assign bus.cmd_index_error = cmd_index_error_q;
  assign bus.REQ_out         = req_out_q;
  assign bus.ACK_out         = ack_out_q;
  assign bus.timeout_error   = timeout_error_q;
  assign bus.response_arg    = response_arg_q;
  assign bus.response_index  = response_index_q;
  assign bus.cmd_out         = cmd_out_q;

endmodule

// File: tb/tb_cmd_master.sv
// Self-checking bench for cmd_master: directed vector table, hand-written corner sequences and
// randomized commands checked against a transaction-level outcome model.
module tb_cmd_master;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  cmd_master_if bus ();

  cmd_master dut (
    .CLK_host (clk),
    .reset    (rst_n),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  idx;
    logic [31:0] arg;
    logic [15:0] tv;
    int          ack_dly;
    int          resp_dly;
    logic [37:0] resp;
    int          hold;
    logic        exp_cmp;
    logic        exp_ierr;
    logic        exp_tmo;
  } vec_t;

  vec_t vecs[7];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_busy"}, 64'(bus.cmd_busy), 0);
    check({name, "_cmp"}, 64'(bus.cmd_complete), 0);
    check({name, "_ierr"}, 64'(bus.cmd_index_error), 0);
    check({name, "_req"}, 64'(bus.REQ_out), 0);
    check({name, "_ack"}, 64'(bus.ACK_out), 0);
    check({name, "_tmo"}, 64'(bus.timeout_error), 0);
    check({name, "_rarg"}, 64'(bus.response_arg), 0);
    check({name, "_ridx"}, 64'(bus.response_index), 0);
    check({name, "_cmdout"}, 64'(bus.cmd_out), 0);
  endtask

  // Outcome of one command from the handshake timing alone: response arrives on WAIT edge
  // resp_dly+1, the timeout fires on WAIT edge tv; a tie goes to the response.
  function automatic logic model_tmo(input logic [15:0] tv, input int resp_dly);
    return (tv != 16'd0) && (int'(tv) <= resp_dly);
  endfunction

  task automatic run_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic [15:0] tv,
                         input int ack_dly, input int resp_dly, input logic [37:0] resp,
                         input int hold, input logic exp_cmp, input logic exp_ierr,
                         input logic exp_tmo);
    bus.cmd_index     = idx;
    bus.cmd_arg       = arg;
    bus.timeout_value = tv;
    bus.new_cmd       = 1'b1;
    tick();
    bus.new_cmd   = 1'b0;
    bus.cmd_index = 6'($urandom);
    bus.cmd_arg   = $urandom;
    check("accept_busy", 64'(bus.cmd_busy), 1);
    check("accept_req", 64'(bus.REQ_out), 1);
    check("accept_cmd_out", 64'(bus.cmd_out), 64'({idx, arg}));
    check("accept_tmo_clr", 64'(bus.timeout_error), 0);
    check("accept_ierr_clr", 64'(bus.cmd_index_error), 0);
    for (int i = 0; i < ack_dly; i++) begin
      tick();
      check("req_hold", 64'(bus.REQ_out), 1);
    end
    bus.ACK_in = 1'b1;
    tick();
    bus.ACK_in = 1'b0;
    check("req_drop", 64'(bus.REQ_out), 0);
    check("send_busy", 64'(bus.cmd_busy), 1);
    for (int i = 1; i <= resp_dly; i++) begin
      tick();
      if (exp_tmo && (i == int'(tv))) begin
        check("tmo_flag", 64'(bus.timeout_error), 1);
        check("tmo_busy", 64'(bus.cmd_busy), 0);
        check("tmo_cmp", 64'(bus.cmd_complete), 0);
        tick();
        check("tmo_hold", 64'(bus.timeout_error), 1);
        check("tmo_no_cmp", 64'(bus.cmd_complete), 0);
        return;
      end
      check("wait_busy", 64'(bus.cmd_busy), 1);
      check("wait_tmo", 64'(bus.timeout_error), 0);
    end
    bus.REQ_in       = 1'b1;
    bus.cmd_response = resp;
    tick();
    bus.cmd_response = {6'($urandom), 32'($urandom)};
    check("resp_ack", 64'(bus.ACK_out), 1);
    check("resp_idx", 64'(bus.response_index), 64'(resp[37:32]));
    check("resp_arg", 64'(bus.response_arg), 64'(resp[31:0]));
    check("resp_ierr", 64'(bus.cmd_index_error), 64'(exp_ierr));
    check("resp_tmo", 64'(bus.timeout_error), 0);
    for (int h = 0; h < hold; h++) begin
      tick();
      check("ack_hold", 64'(bus.ACK_out), 1);
    end
    bus.REQ_in = 1'b0;
    tick();
    check("ack_drop", 64'(bus.ACK_out), 0);
    check("done_busy", 64'(bus.cmd_busy), 1);
    check("done_cmp_early", 64'(bus.cmd_complete), 0);
    tick();
    check("cmp_pulse", 64'(bus.cmd_complete), 64'(exp_cmp));
    check("cmp_busy", 64'(bus.cmd_busy), 0);
    tick();
    check("cmp_one_cycle", 64'(bus.cmd_complete), 0);
    check("resp_arg_hold", 64'(bus.response_arg), 64'(resp[31:0]));
    check("ierr_hold", 64'(bus.cmd_index_error), 64'(exp_ierr));
  endtask

  initial begin
    vecs[0] = '{6'h3F, 32'hAAAAAAAA, 16'd15, 4, 2, {6'h39, 32'h76543210}, 1, 1'b1, 1'b1, 1'b0};
    vecs[1] = '{6'h11, 32'h12345678, 16'd15, 0, 3, {6'h11, 32'hDEADBEEF}, 0, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{6'h05, 32'h00000000, 16'd5, 1, 10, {6'h05, 32'h0}, 0, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{6'h2A, 32'hCAFEF00D, 16'd5, 0, 4, {6'h2A, 32'h0BADCAFE}, 2, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{6'h01, 32'h00000001, 16'd1, 2, 0, {6'h01, 32'hFFFFFFFF}, 0, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{6'h02, 32'h00000002, 16'd1, 0, 1, {6'h02, 32'h0}, 0, 1'b0, 1'b0, 1'b1};
    vecs[6] = '{6'h07, 32'h55555555, 16'd0, 1, 40, {6'h08, 32'h13579BDF}, 1, 1'b1, 1'b1, 1'b0};

    bus.new_cmd = 0; bus.cmd_error = 0; bus.ACK_in = 0; bus.REQ_in = 0;
    bus.cmd_arg = 0; bus.cmd_index = 0; bus.timeout_value = 0; bus.cmd_response = 0;

    // Reset with random activity on the inputs.
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.new_cmd      = 1'($urandom);
      bus.cmd_error    = 1'($urandom);
      bus.ACK_in       = 1'($urandom);
      bus.REQ_in       = 1'($urandom);
      bus.cmd_arg      = $urandom;
      bus.cmd_index    = 6'($urandom);
      bus.cmd_response = {6'($urandom), 32'($urandom)};
      tick();
    end
    check_all_zero("reset");
    bus.new_cmd = 0; bus.cmd_error = 0; bus.ACK_in = 0; bus.REQ_in = 0;
    rst_n = 1'b1;
    tick();

    foreach (vecs[v])
      run_cmd(vecs[v].idx, vecs[v].arg, vecs[v].tv, vecs[v].ack_dly, vecs[v].resp_dly,
              vecs[v].resp, vecs[v].hold, vecs[v].exp_cmp, vecs[v].exp_ierr, vecs[v].exp_tmo);

    // cmd_error beats ACK_in on the same edge in SEND.
    bus.cmd_index = 6'h0A; bus.cmd_arg = 32'h1; bus.timeout_value = 16'd0; bus.new_cmd = 1'b1;
    tick();
    bus.new_cmd = 1'b0; bus.cmd_error = 1'b1; bus.ACK_in = 1'b1;
    tick();
    bus.cmd_error = 1'b0; bus.ACK_in = 1'b0;
    check("err_send_req", 64'(bus.REQ_out), 0);
    check("err_send_busy", 64'(bus.cmd_busy), 0);
    tick();
    check("err_send_idle", 64'(bus.cmd_busy), 0);

    // cmd_error in WAIT_RESP.
    bus.new_cmd = 1'b1;
    tick();
    bus.new_cmd = 1'b0; bus.ACK_in = 1'b1;
    tick();
    bus.ACK_in = 1'b0;
    tick();
    tick();
    bus.cmd_error = 1'b1;
    tick();
    bus.cmd_error = 1'b0;
    check("err_wait_busy", 64'(bus.cmd_busy), 0);
    check("err_wait_req", 64'(bus.REQ_out), 0);
    check("err_wait_ack", 64'(bus.ACK_out), 0);
    check("err_wait_cmp", 64'(bus.cmd_complete), 0);
    tick();
    check("err_wait_cmp2", 64'(bus.cmd_complete), 0);

    // cmd_error in ACK drops ACK_out.
    bus.new_cmd = 1'b1;
    tick();
    bus.new_cmd = 1'b0; bus.ACK_in = 1'b1;
    tick();
    bus.ACK_in = 1'b0; bus.REQ_in = 1'b1; bus.cmd_response = {6'h0A, 32'h77};
    tick();
    check("err_ack_pre", 64'(bus.ACK_out), 1);
    bus.cmd_error = 1'b1;
    tick();
    bus.cmd_error = 1'b0; bus.REQ_in = 1'b0;
    check("err_ack_ack", 64'(bus.ACK_out), 0);
    check("err_ack_busy", 64'(bus.cmd_busy), 0);
    tick();
    check("err_ack_cmp", 64'(bus.cmd_complete), 0);

    // new_cmd held high while busy; restarts only after DONE.
    bus.cmd_index = 6'h11; bus.cmd_arg = 32'h1111; bus.timeout_value = 16'd20; bus.new_cmd = 1'b1;
    tick();
    bus.cmd_index = 6'h22; bus.cmd_arg = 32'h2222;
    tick();
    check("busy_cmd_out", 64'(bus.cmd_out), 64'({6'h11, 32'h1111}));
    bus.ACK_in = 1'b1;
    tick();
    bus.ACK_in = 1'b0; bus.REQ_in = 1'b1; bus.cmd_response = {6'h11, 32'h9};
    tick();
    bus.REQ_in = 1'b0;
    tick();
    check("busy_cmd_out2", 64'(bus.cmd_out), 64'({6'h11, 32'h1111}));
    tick();
    check("busy_cmp", 64'(bus.cmd_complete), 1);
    check("busy_cmd_out3", 64'(bus.cmd_out), 64'({6'h11, 32'h1111}));
    tick();
    bus.new_cmd = 1'b0;
    check("restart_busy", 64'(bus.cmd_busy), 1);
    check("restart_cmd_out", 64'(bus.cmd_out), 64'({6'h22, 32'h2222}));
    check("restart_cmp", 64'(bus.cmd_complete), 0);

    // Synchronous reset while in ACK.
    bus.ACK_in = 1'b1;
    tick();
    bus.ACK_in = 1'b0; bus.REQ_in = 1'b1; bus.cmd_response = {6'h22, 32'h3};
    tick();
    check("rst_ack_pre", 64'(bus.ACK_out), 1);
    rst_n = 1'b0;
    tick();
    check_all_zero("rst_ack");
    rst_n = 1'b1; bus.REQ_in = 1'b0;
    tick();
    check("rst_ack_cmp", 64'(bus.cmd_complete), 0);

    // Randomized commands against the outcome model.
    for (int r = 0; r < 25; r++) begin
      logic [5:0]  idx;
      logic [31:0] arg;
      logic [15:0] tv;
      logic [37:0] resp;
      int          ack_dly, resp_dly, hold;
      logic        tmo;
      idx      = 6'($urandom);
      arg      = $urandom;
      tv       = 16'($urandom_range(0, 8));
      ack_dly  = int'($urandom_range(0, 3));
      resp_dly = int'($urandom_range(0, 10));
      hold     = int'($urandom_range(0, 2));
      resp     = {($urandom_range(0, 1) == 0) ? idx : 6'($urandom), 32'($urandom)};
      tmo      = model_tmo(tv, resp_dly);
      run_cmd(idx, arg, tv, ack_dly, resp_dly, resp, hold, !tmo,
              !tmo && (resp[37:32] != idx), tmo);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
